cache_line_fill: RTL and testbench

Line refill engine sitting directly downstream of a cache miss and upstream of the memory bus. It accepts one miss address from the 16KB 4-way instruction or data cache and performs four 32-bit bus reads in critical-word-first wrap order. It forwards the critical longword early and assembles the 149-bit cache line `[TAG][V][L0][L1][L2][L3]` for the cache to write into the selected way.

---
 rtl/cache_pkg.sv | 30 +++
 rtl/line_buffer.sv | 43 ++++
 rtl/cache_line_fill.sv | 136 +++++++++++++
 tb/tb_cache_line_fill.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the instruction and data cache refill path:
// line geometry, field offsets, miss-address slices and fill FSM states.
package cache_pkg;

    localparam int TAG_W  = 20;
    localparam int IDX_W  = 8;
    localparam int LINE_W = TAG_W + 1 + 128;

    // Field positions inside an assembled line [TAG][V][L0][L1][L2][L3]
    localparam int TAG_LSB = 129;
    localparam int V_BIT   = 128;
    localparam int L0_LSB  = 96;

    // Miss byte address slices
    localparam int ADDR_TAG_LSB = 12;
    localparam int ADDR_IDX_LSB = 4;
    localparam int ADDR_PTR_LSB = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_FILL = 2'd2
    } fill_state_e;

    // Critical-word-first wrap: longword slot for a given beat count.
    function automatic logic [1:0] wrap_ptr(input logic [1:0] start, input logic [2:0] count);
        return start + count[1:0];
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Four-longword refill buffer. Slot 0 is L0 (bits [127:96]), slot 3 is L3.
// line_o shows the contents with the current write already merged in.
module line_buffer (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         wr_en_i,
    input  logic [1:0]   wr_ptr_i,
    input  logic [31:0]  wr_data_i,
    output logic [127:0] line_o
);

    logic [127:0] line_q;
    logic [127:0] line_d;

    // Next contents: overwrite the addressed slot when a beat lands.
    always_comb begin
        line_d = line_q;
        if (wr_en_i) begin
            case (wr_ptr_i)
                2'd0:    line_d[127:96] = wr_data_i;
                2'd1:    line_d[95:64]  = wr_data_i;
                2'd2:    line_d[63:32]  = wr_data_i;
                2'd3:    line_d[31:0]   = wr_data_i;
                default: line_d         = line_q;
            endcase
        end else begin
            line_d = line_q;
        end
    end

    // Storage register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            line_q <= {128{1'b0}};
        end else begin
            line_q <= line_d;
        end
    end

    // Write-through view lets the final beat and the line register load together.
    assign line_o = line_d;

endmodule

// File: rtl/cache_line_fill.sv
// Cache line refill engine: four critical-word-first bus reads, early
// critical-word forward, and one-shot delivery of the assembled line.
module cache_line_fill #(
    parameter int TAG_W  = cache_pkg::TAG_W,
    parameter int IDX_W  = cache_pkg::IDX_W,
    parameter int LINE_W = TAG_W + 1 + 128
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              MISS_VALID,
    input  logic [31:0]       MISS_ADDR,
    output logic              MISS_READY,
    output logic              BUS_REQ,
    output logic [31:0]       BUS_ADDR,
    input  logic              BUS_ACK,
    input  logic [31:0]       BUS_DATA,
    input  logic              BUS_ERR,
    output logic              CW_VALID,
    output logic [31:0]       CW_DATA,
    output logic              FILL_VALID,
    output logic [IDX_W-1:0]  FILL_INDEX,
    output logic [LINE_W-1:0] FILL_LINE,
    output logic              FILL_ERR
);

    import cache_pkg::*;

    fill_state_e       state_q;
    logic [2:0]        count_q;
    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  idx_q;
    logic [1:0]        start_q;
    logic              cw_valid_q;
    logic [31:0]       cw_data_q;
    logic              fill_valid_q;
    logic              fill_err_q;
    logic [IDX_W-1:0]  fill_index_q;
    logic [LINE_W-1:0] fill_line_q;

    logic [1:0]        ptr;
    logic              beat_ack;
    logic [127:0]      buf_line;
    logic              unused_addr;

    assign ptr         = wrap_ptr(start_q, count_q);
    assign beat_ack    = (state_q == ST_BEAT) && BUS_ACK && !BUS_ERR;
    assign unused_addr = ^MISS_ADDR[1:0];

    line_buffer u_line_buffer (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .wr_en_i   (beat_ack),
        .wr_ptr_i  (ptr),
        .wr_data_i (BUS_DATA),
        .line_o    (buf_line)
    );

    // Fill FSM with beat counter and registered handshake/result outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            count_q      <= 3'd0;
            tag_q        <= {TAG_W{1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            start_q      <= 2'd0;
            cw_valid_q   <= 1'b0;
            cw_data_q    <= 32'h0000_0000;
            fill_valid_q <= 1'b0;
            fill_err_q   <= 1'b0;
            fill_index_q <= {IDX_W{1'b0}};
            fill_line_q  <= {LINE_W{1'b0}};
        end else begin
            cw_valid_q   <= 1'b0;
            fill_valid_q <= 1'b0;
            fill_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (MISS_VALID) begin
                        tag_q   <= MISS_ADDR[31:ADDR_TAG_LSB];
                        idx_q   <= MISS_ADDR[ADDR_TAG_LSB-1:ADDR_IDX_LSB];
                        start_q <= MISS_ADDR[ADDR_IDX_LSB-1:ADDR_PTR_LSB];
                        count_q <= 3'd0;
                        state_q <= ST_BEAT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BEAT: begin
                    // An error beat outranks a simultaneous ack and drops the line.
                    if (BUS_ERR) begin
                        fill_err_q <= 1'b1;
                        count_q    <= 3'd0;
                        state_q    <= ST_IDLE;
                    end else if (BUS_ACK) begin
                        count_q <= count_q + 3'd1;
                        if (count_q == 3'd0) begin
                            cw_valid_q <= 1'b1;
                            cw_data_q  <= BUS_DATA;
                        end else begin
                            cw_valid_q <= 1'b0;
                        end
                        if (count_q == 3'd3) begin
                            fill_valid_q <= 1'b1;
                            fill_index_q <= idx_q;
                            fill_line_q  <= {tag_q, 1'b1, buf_line};
                            state_q      <= ST_FILL;
                        end else begin
                            state_q <= ST_BEAT;
                        end
                    end else begin
                        state_q <= ST_BEAT;
                    end
                end
                ST_FILL: begin
                    count_q <= 3'd0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    count_q <= 3'd0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign MISS_READY = (state_q == ST_IDLE);
    assign BUS_REQ    = (state_q == ST_BEAT);
    assign BUS_ADDR   = {tag_q, idx_q, ptr, 2'b00};
    assign CW_VALID   = cw_valid_q;
    assign CW_DATA    = cw_data_q;
    assign FILL_VALID = fill_valid_q;
    assign FILL_INDEX = fill_index_q;
    assign FILL_LINE  = fill_line_q;
    assign FILL_ERR   = fill_err_q;

endmodule

// File: tb/tb_cache_line_fill.sv
// Scoreboard bench for cache_line_fill: directed misses push expected bus
// addresses and pulses; a negedge monitor pops and compares them.
module tb_cache_line_fill;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         MISS_VALID;
    logic [31:0]  MISS_ADDR;
    logic         MISS_READY;
    logic         BUS_REQ;
    logic [31:0]  BUS_ADDR;
    logic         BUS_ACK;
    logic [31:0]  BUS_DATA;
    logic         BUS_ERR;
    logic         CW_VALID;
    logic [31:0]  CW_DATA;
    logic         FILL_VALID;
    logic [7:0]   FILL_INDEX;
    logic [148:0] FILL_LINE;
    logic         FILL_ERR;

    cache_line_fill dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .MISS_VALID (MISS_VALID),
        .MISS_ADDR  (MISS_ADDR),
        .MISS_READY (MISS_READY),
        .BUS_REQ    (BUS_REQ),
        .BUS_ADDR   (BUS_ADDR),
        .BUS_ACK    (BUS_ACK),
        .BUS_DATA   (BUS_DATA),
        .BUS_ERR    (BUS_ERR),
        .CW_VALID   (CW_VALID),
        .CW_DATA    (CW_DATA),
        .FILL_VALID (FILL_VALID),
        .FILL_INDEX (FILL_INDEX),
        .FILL_LINE  (FILL_LINE),
        .FILL_ERR   (FILL_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } cw_exp_t;

    typedef struct {
        logic [7:0]   idx;
        logic [148:0] line;
        int           cyc;
    } fill_exp_t;

    int          checks = 0;
    int          errors = 0;
    int          ncyc   = 0;
    int          last_acc;
    int          last_fill;
    logic [31:0] addr_q[$];
    cw_exp_t     cw_q[$];
    fill_exp_t   fill_q[$];
    int          err_q[$];

    always @(posedge CLK) ncyc <= ncyc + 1;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // Monitor: compare every presented DUT event against the scoreboard.
    always @(negedge CLK) begin : monitor
        cw_exp_t   c;
        fill_exp_t f;
        int        e;
        if (!RESET) begin
            if (BUS_REQ && (BUS_ACK || BUS_ERR)) begin
                if (addr_q.size() == 0) chk("bus_addr_unexpected", 160'(BUS_ADDR), 160'(32'hFFFF_FFFF));
                else chk("bus_addr", 160'(BUS_ADDR), 160'(addr_q.pop_front()));
            end else if (BUS_REQ && addr_q.size() != 0) begin
                chk("bus_addr_hold", 160'(BUS_ADDR), 160'(addr_q[0]));
            end
            if (CW_VALID) begin
                if (cw_q.size() == 0) chk("cw_unexpected", 160'(1), 160'(0));
                else begin
                    c = cw_q.pop_front();
                    chk("cw_data", 160'(CW_DATA), 160'(c.data));
                    chk("cw_cycle", 160'(ncyc), 160'(c.cyc));
                end
            end
            if (FILL_VALID) begin
                if (fill_q.size() == 0) chk("fill_unexpected", 160'(1), 160'(0));
                else begin
                    f = fill_q.pop_front();
                    chk("fill_line", 160'(FILL_LINE), 160'(f.line));
                    chk("fill_index", 160'(FILL_INDEX), 160'(f.idx));
                    chk("fill_cycle", 160'(ncyc), 160'(f.cyc));
                end
            end
            if (FILL_ERR) begin
                if (err_q.size() == 0) chk("err_unexpected", 160'(1), 160'(0));
                else begin
                    e = err_q.pop_front();
                    chk("err_cycle", 160'(ncyc), 160'(e));
                end
            end
        end
    end

    // One miss: gap = idle cycles before each ack, err_beat/rst_beat = -1 for none.
    task automatic run_miss(input logic [31:0] addr, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3, input int gap,
                            input int err_beat, input int rst_beat, input logic hold,
                            input logic [31:0] next_addr, input int exp_acc);
        logic [31:0] data [4];
        logic [31:0] slot [4];
        logic [1:0]  ptr;
        int          n;
        data[0] = d0; data[1] = d1; data[2] = d2; data[3] = d3;
        for (int i = 0; i < 4; i++) slot[i] = 32'h0;
        MISS_VALID = 1'b1;
        MISS_ADDR  = addr;
        n = 0;
        while (!MISS_READY && n < 50) begin
            @(posedge CLK); #1; n++;
        end
        chk("miss_accept", 160'(MISS_READY), 160'(1));
        last_acc = ncyc;
        if (exp_acc >= 0) chk("accept_cycle", 160'(last_acc), 160'(exp_acc));
        @(posedge CLK); #1;
        if (hold) MISS_ADDR = next_addr;
        else MISS_VALID = 1'b0;
        chk("req_start", 160'(BUS_REQ), 160'(1));
        for (int b = 0; b < 4; b++) begin
            if (b == rst_beat) begin
                RESET   = 1'b1;
                BUS_ACK = 1'b0;
                @(posedge CLK); #1;
                RESET = 1'b0;
                chk("rst_req", 160'(BUS_REQ), 160'(0));
                chk("rst_ready", 160'(MISS_READY), 160'(1));
                chk("rst_cw_data", 160'(CW_DATA), 160'(0));
                chk("rst_fill_line", 160'(FILL_LINE), 160'(0));
                chk("rst_pulses", 160'({CW_VALID, FILL_VALID, FILL_ERR}), 160'(0));
                return;
            end
            ptr = addr[3:2] + b[1:0];
            addr_q.push_back({addr[31:4], ptr, 2'b00});
            for (int w = 0; w < gap; w++) begin
                BUS_ACK = 1'b0;
                BUS_ERR = 1'b0;
                @(posedge CLK); #1;
            end
            chk("ready_busy", 160'(MISS_READY), 160'(0));
            BUS_ACK  = 1'b1;
            BUS_DATA = data[b];
            BUS_ERR  = (b == err_beat);
            if (b == 0) cw_q.push_back('{data: data[0], cyc: ncyc + 1});
            if (b == err_beat) begin
                err_q.push_back(ncyc + 1);
                @(posedge CLK); #1;
                BUS_ACK = 1'b0;
                BUS_ERR = 1'b0;
                chk("req_drop_err", 160'(BUS_REQ), 160'(0));
                n = 0;
                while (!MISS_READY && n < 10) begin
                    @(posedge CLK); #1; n++;
                end
                chk("ready_after_err", 160'(MISS_READY), 160'(1));
                return;
            end
            slot[ptr] = data[b];
            if (b == 3)
                fill_q.push_back('{idx: addr[11:4],
                                   line: {addr[31:12], 1'b1, slot[0], slot[1], slot[2], slot[3]},
                                   cyc: ncyc + 1});
            @(posedge CLK); #1;
        end
        BUS_ACK = 1'b0;
        chk("req_drop", 160'(BUS_REQ), 160'(0));
        last_fill = ncyc;
        @(posedge CLK); #1;
        chk("ready_after_fill", 160'(MISS_READY), 160'(1));
    endtask

    initial begin
        RESET      = 1'b1;
        MISS_VALID = 1'b0;
        MISS_ADDR  = 32'h0;
        BUS_ACK    = 1'b0;
        BUS_DATA   = 32'h0;
        BUS_ERR    = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;

        chk("reset_ready", 160'(MISS_READY), 160'(1));
        chk("reset_req", 160'(BUS_REQ), 160'(0));
        chk("reset_pulses", 160'({CW_VALID, FILL_VALID, FILL_ERR}), 160'(0));
        chk("reset_line", 160'(FILL_LINE), 160'(0));
        chk("reset_cw_data", 160'(CW_DATA), 160'(0));
        chk("reset_index", 160'(FILL_INDEX), 160'(0));

        // Aligned miss, zero-wait bus
        run_miss(32'h0001_2340, 32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3,
                 0, -1, -1, 1'b0, 32'h0, -1);
        chk("aligned_fill_at_t5", 160'(last_fill), 160'(last_acc + 5));
        chk("aligned_line", 160'(FILL_LINE),
            160'({20'h00012, 1'b1, 32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3}));
        chk("aligned_index", 160'(FILL_INDEX), 160'(8'h34));

        // Wrap order starting at slot 2
        run_miss(32'h0000_0F38, 32'h0000_00B0, 32'h0000_00B1, 32'h0000_00B2, 32'h0000_00B3,
                 0, -1, -1, 1'b0, 32'h0, -1);
        chk("wrap_line", 160'(FILL_LINE),
            160'({20'h00000, 1'b1, 32'h0000_00B2, 32'h0000_00B3, 32'h0000_00B0, 32'h0000_00B1}));
        chk("wrap_cw_data", 160'(CW_DATA), 160'(32'h0000_00B0));

        // Wait states: ack every third cycle
        run_miss(32'h0ABC_D004, 32'hC0C0_0000, 32'hC1C1_0001, 32'hC2C2_0002, 32'hC3C3_0003,
                 2, -1, -1, 1'b0, 32'h0, -1);
        chk("wait_line", 160'(FILL_LINE),
            160'({20'h0ABCD, 1'b1, 32'hC3C3_0003, 32'hC0C0_0000, 32'hC1C1_0001, 32'hC2C2_0002}));

        // Bus error with ack on third beat, then a clean fill
        run_miss(32'h0000_5678, 32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003,
                 0, 2, -1, 1'b0, 32'h0, -1);
        chk("err_line_kept", 160'(FILL_LINE),
            160'({20'h0ABCD, 1'b1, 32'hC3C3_0003, 32'hC0C0_0000, 32'hC1C1_0001, 32'hC2C2_0002}));
        run_miss(32'h0000_5670, 32'hE000_0000, 32'hE000_0001, 32'hE000_0002, 32'hE000_0003,
                 0, -1, -1, 1'b0, 32'h0, -1);
        chk("post_err_line", 160'(FILL_LINE),
            160'({20'h00005, 1'b1, 32'hE000_0000, 32'hE000_0001, 32'hE000_0002, 32'hE000_0003}));

        // Reset after two beats, then a fresh miss
        run_miss(32'h0000_9990, 32'hF000_0000, 32'hF000_0001, 32'hF000_0002, 32'hF000_0003,
                 0, -1, 2, 1'b0, 32'h0, -1);
        run_miss(32'h0000_999C, 32'h1111_0000, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003,
                 0, -1, -1, 1'b0, 32'h0, -1);
        chk("post_rst_line", 160'(FILL_LINE),
            160'({20'h00009, 1'b1, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003, 32'h1111_0000}));

        // Back-pressure: second miss held during the first fill
        run_miss(32'h0000_1110, 32'h2222_0000, 32'h2222_0001, 32'h2222_0002, 32'h2222_0003,
                 0, -1, -1, 1'b1, 32'h0000_2224, -1);
        run_miss(32'h0000_2224, 32'h3333_0000, 32'h3333_0001, 32'h3333_0002, 32'h3333_0003,
                 0, -1, -1, 1'b0, 32'h0, last_fill + 1);
        chk("bp_line", 160'(FILL_LINE),
            160'({20'h00002, 1'b1, 32'h3333_0003, 32'h3333_0000, 32'h3333_0001, 32'h3333_0002}));

        repeat (4) @(posedge CLK);
        #1;
        chk("sb_addr_drained", 160'(addr_q.size()), 160'(0));
        chk("sb_cw_drained", 160'(cw_q.size()), 160'(0));
        chk("sb_fill_drained", 160'(fill_q.size()), 160'(0));
        chk("sb_err_drained", 160'(err_q.size()), 160'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", ncyc);
        $fatal(1, "watchdog");
    end

endmodule
